// File: rtl/trap_unit.sv
// Trap controller: priority-encodes EX trap requests, kills the faulting
// write, redirects to a per-cause vector one cycle later, and keeps a
// {cause, EPC} nesting stack unwound by return-from-trap.
//
// state  | meaning
// RUN    | normal execution; captures traps and returns
// ENTER  | one-cycle redirect pulse into a trap vector
// RETURN | one-cycle redirect pulse back to EPC + 1
// HALT   | double fault; only reset leaves this state
module trap_unit #(
  parameter int                 N_SRC     = 4,
  parameter int                 ADDR_W    = 48,
  parameter logic [ADDR_W-1:0]  VEC_BASE  = ADDR_W'(48'h0000_0100),
  parameter int                 VEC_SHIFT = 4,
  parameter int                 DEPTH     = 2,
  parameter int                 CAUSE_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                         iw_clk,
  input  logic                         iw_rst,
  input  logic [N_SRC-1:0]             iw_trap_req,
  input  logic [N_SRC-1:0]             iw_trap_mask,
  input  logic [ADDR_W-1:0]            iw_pc,
  input  logic                         iw_stall,
  input  logic                         iw_rti,
  output logic                         ow_wb_suppress,
  output logic                         ow_branch_taken,
  output logic [ADDR_W-1:0]            ow_branch_pc,
  output logic [CAUSE_W-1:0]           ow_cause,
  output logic [ADDR_W-1:0]            ow_epc,
  output logic [$clog2(DEPTH+1)-1:0]   ow_depth,
  output logic                         ow_in_trap,
  output logic                         ow_double_fault
);

  localparam int DEPTH_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {RUN, ENTER, RETURN, HALT} state_t;

  state_t               state_q, state_d;
  logic [N_SRC-1:0]     eff;
  logic                 any_req;
  logic [CAUSE_W-1:0]   cause;
  logic [ADDR_W-1:0]    vec_pc;
  logic [ADDR_W-1:0]    branch_pc_q, branch_pc_d;
  logic [DEPTH_W-1:0]   depth_q;
  logic                 push, pop, go_halt;
  logic                 df_q;
  logic [CAUSE_W-1:0]   stk_cause [DEPTH];
  logic [ADDR_W-1:0]    stk_epc   [DEPTH];
  logic [CAUSE_W-1:0]   top_cause;
  logic [ADDR_W-1:0]    top_epc;

  assign eff     = iw_trap_req & iw_trap_mask;
  assign any_req = |eff;
  assign vec_pc  = VEC_BASE + (ADDR_W'(cause) << VEC_SHIFT);

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    cause = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (eff[i]) cause = CAUSE_W'(i);
    end
  end

  // Top-of-stack view; zero when the stack is empty.
  always_comb begin
    top_cause = '0;
    top_epc   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DEPTH_W'(i+1) == depth_q) begin
        top_cause = stk_cause[i];
        top_epc   = stk_epc[i];
      end
    end
  end

  // Next-state and stack control; a trap takes precedence over rti.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    pop         = 1'b0;
    go_halt     = 1'b0;
    branch_pc_d = branch_pc_q;
    case (state_q)
      RUN: begin
        if (!iw_stall) begin
          if (any_req) begin
            if (depth_q == DEPTH_W'(DEPTH)) begin
              state_d = HALT;
              go_halt = 1'b1;
            end else begin
              state_d     = ENTER;
              push        = 1'b1;
              branch_pc_d = vec_pc;
            end
          end else if (iw_rti && (depth_q != '0)) begin
            state_d     = RETURN;
            pop         = 1'b1;
            branch_pc_d = top_epc + ADDR_W'(1);
          end
        end
      end
      ENTER, RETURN: state_d = RUN;
      HALT:          state_d = HALT;
      default:       state_d = RUN;
    endcase
  end

  // State, redirect target and sticky double-fault flag.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      state_q     <= RUN;
      branch_pc_q <= '0;
      df_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      branch_pc_q <= branch_pc_d;
      if (go_halt) df_q <= 1'b1;
    end
  end

  // Nesting stack; popped entries are cleared so stale EPCs never linger.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_cause[i] <= '0;
        stk_epc[i]   <= '0;
      end
    end else begin
      if (push)     depth_q <= depth_q + DEPTH_W'(1);
      else if (pop) depth_q <= depth_q - DEPTH_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (DEPTH_W'(i) == depth_q)) begin
          stk_cause[i] <= cause;
          stk_epc[i]   <= iw_pc;
        end else if (pop && (DEPTH_W'(i+1) == depth_q)) begin
          stk_cause[i] <= '0;
          stk_epc[i]   <= '0;
        end
      end
    end
  end

  assign ow_wb_suppress  = (state_q == RUN) && any_req;
  assign ow_branch_taken = (state_q == ENTER) || (state_q == RETURN);
  assign ow_branch_pc    = branch_pc_q;
  assign ow_cause        = top_cause;
  assign ow_epc          = top_epc;
  assign ow_depth        = depth_q;
  assign ow_in_trap      = (depth_q != '0);
  assign ow_double_fault = df_q;

endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the trap stack.
module tb_trap_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [3:0]  mask = 4'hF;
  logic [47:0] pc = 48'h0;
  logic        stall = 1'b0;
  logic        rti = 1'b0;
  logic        supp, taken, in_trap, df;
  logic [47:0] bpc, epc;
  logic [1:0]  cause, depth;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  c;
    logic [47:0] e;
  } ent_t;

  ent_t        stk[$];
  bit          m_halt, m_redir, m_df;
  logic [47:0] m_pc;

  trap_unit #(
    .N_SRC(4), .ADDR_W(48), .VEC_BASE(48'h100), .VEC_SHIFT(4), .DEPTH(DEPTH)
  ) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_trap_req(req), .iw_trap_mask(mask),
    .iw_pc(pc), .iw_stall(stall), .iw_rti(rti),
    .ow_wb_suppress(supp), .ow_branch_taken(taken), .ow_branch_pc(bpc),
    .ow_cause(cause), .ow_epc(epc), .ow_depth(depth), .ow_in_trap(in_trap),
    .ow_double_fault(df)
  );

  always #5 clk = ~clk;

  function automatic bit m_supp();
    return !m_halt && !m_redir && ((req & mask) != 4'h0);
  endfunction

  function automatic logic [1:0] m_cause();
    return (stk.size() > 0) ? stk[$].c : 2'd0;
  endfunction

  function automatic logic [47:0] m_epc();
    return (stk.size() > 0) ? stk[$].e : 48'd0;
  endfunction

  // Apply one clock edge of the trap rules to the model using current inputs.
  task automatic model_edge();
    logic [3:0] eff;
    bit         busy;
    int         c;
    eff = req & mask;
    busy = m_redir;
    m_redir = 1'b0;
    c = 0;
    if (m_halt || busy || stall) return;
    if (eff != 4'h0) begin
      for (int i = 3; i >= 0; i--) if (eff[i]) c = i;
      if (stk.size() == DEPTH) begin
        m_halt = 1'b1;
        m_df = 1'b1;
      end else begin
        stk.push_back('{c: 2'(c), e: pc});
        m_redir = 1'b1;
        m_pc = 48'h100 + 48'(c) * 48'd16;
      end
    end else if (rti && stk.size() > 0) begin
      m_pc = stk[$].e + 48'd1;
      void'(stk.pop_back());
      m_redir = 1'b1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 4'h0; rti = 1'b0; stall = 1'b0; mask = 4'hF; pc = 48'h0;
    stk.delete();
    m_halt = 1'b0; m_redir = 1'b0; m_df = 1'b0; m_pc = 48'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({taken, bpc, cause, epc, depth, in_trap, df} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got taken=%b pc=%h cause=%0d epc=%h depth=%0d in_trap=%b df=%b required all 0",
               taken, bpc, cause, epc, depth, in_trap, df);
    end
    do_reset();
    checks++;
    if (taken !== 1'b0 || depth !== 2'd0 || supp !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got taken=%b depth=%0d supp=%b required 0 0 0", taken, depth, supp);
    end
  endtask

  task automatic test_single_trap();
    do_reset();
    pc = 48'h400; req = 4'b0100;
    #1;
    checks++;
    if (supp !== 1'b1) begin errors++; $display("FAIL single_suppress got %b required 1", supp); end
    cycle();
    req = 4'h0;
    checks++;
    if (taken !== 1'b1 || bpc !== 48'h120 || cause !== 2'd2 || epc !== 48'h400 || depth !== 2'd1 || in_trap !== 1'b1) begin
      errors++;
      $display("FAIL single_enter got taken=%b pc=%h cause=%0d epc=%h depth=%0d in_trap=%b required 1 120 2 400 1 1",
               taken, bpc, cause, epc, depth, in_trap);
    end
    cycle();
    checks++;
    if (taken !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %b required 0", taken); end
  endtask

  task automatic test_priority_mask();
    do_reset();
    req = 4'b1010; mask = 4'b1101; pc = 48'h700;
    cycle();
    req = 4'h0;
    checks++;
    if (taken !== 1'b1 || bpc !== 48'h130 || cause !== 2'd3) begin
      errors++;
      $display("FAIL prio_mask got taken=%b pc=%h cause=%0d required 1 130 3", taken, bpc, cause);
    end
    cycle();
    do_reset();
    req = 4'b0010; mask = 4'b1101;
    #1;
    checks++;
    if (supp !== 1'b0) begin errors++; $display("FAIL masked_suppress got %b required 0", supp); end
    cycle();
    checks++;
    if (taken !== 1'b0 || depth !== 2'd0) begin
      errors++;
      $display("FAIL masked_redirect got taken=%b depth=%0d required 0 0", taken, depth);
    end
    req = 4'h0; mask = 4'hF;
  endtask

  task automatic fill_two();
    do_reset();
    pc = 48'h400; req = 4'b0001; cycle();
    req = 4'h0; cycle();
    pc = 48'h500; req = 4'b0010; cycle();
    req = 4'h0; cycle();
  endtask

  task automatic test_nesting();
    fill_two();
    checks++;
    if (depth !== 2'd2 || cause !== 2'd1 || epc !== 48'h500) begin
      errors++;
      $display("FAIL nest_top got depth=%0d cause=%0d epc=%h required 2 1 500", depth, cause, epc);
    end
    rti = 1'b1; cycle(); rti = 1'b0;
    checks++;
    if (taken !== 1'b1 || bpc !== 48'h501 || depth !== 2'd1 || cause !== 2'd0 || epc !== 48'h400) begin
      errors++;
      $display("FAIL rti_first got taken=%b pc=%h depth=%0d cause=%0d epc=%h required 1 501 1 0 400",
               taken, bpc, depth, cause, epc);
    end
    cycle();
    rti = 1'b1; cycle(); rti = 1'b0;
    checks++;
    if (taken !== 1'b1 || bpc !== 48'h401 || depth !== 2'd0 || in_trap !== 1'b0 || epc !== 48'h0) begin
      errors++;
      $display("FAIL rti_second got taken=%b pc=%h depth=%0d in_trap=%b epc=%h required 1 401 0 0 0",
               taken, bpc, depth, in_trap, epc);
    end
    cycle();
    rti = 1'b1; cycle(); rti = 1'b0;
    checks++;
    if (taken !== 1'b0 || depth !== 2'd0) begin
      errors++;
      $display("FAIL rti_empty got taken=%b depth=%0d required 0 0", taken, depth);
    end
  endtask

  task automatic test_double_fault();
    fill_two();
    req = 4'b0001; pc = 48'h900; cycle();
    checks++;
    if (df !== 1'b1 || taken !== 1'b0 || depth !== 2'd2 || epc !== 48'h500) begin
      errors++;
      $display("FAIL double_fault got df=%b taken=%b depth=%0d epc=%h required 1 0 2 500", df, taken, depth, epc);
    end
    rti = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req = 4'b0010;
      #1;
      checks++;
      if (supp !== 1'b0) begin errors++; $display("FAIL halt_suppress got %b required 0", supp); end
      cycle();
      checks++;
      if (taken !== 1'b0 || depth !== 2'd2 || df !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold got taken=%b depth=%0d df=%b required 0 2 1", taken, depth, df);
      end
    end
    do_reset();
    checks++;
    if (df !== 1'b0 || depth !== 2'd0) begin
      errors++;
      $display("FAIL halt_exit got df=%b depth=%0d required 0 0", df, depth);
    end
  endtask

  task automatic test_stall_collision();
    do_reset();
    req = 4'b0100; pc = 48'h400; stall = 1'b1;
    #1;
    checks++;
    if (supp !== 1'b1) begin errors++; $display("FAIL stall_suppress got %b required 1", supp); end
    cycle();
    checks++;
    if (taken !== 1'b0 || depth !== 2'd0) begin
      errors++;
      $display("FAIL stall_capture got taken=%b depth=%0d required 0 0", taken, depth);
    end
    stall = 1'b0; cycle(); req = 4'h0;
    checks++;
    if (taken !== 1'b1 || depth !== 2'd1 || bpc !== 48'h120) begin
      errors++;
      $display("FAIL stall_release got taken=%b depth=%0d pc=%h required 1 1 120", taken, depth, bpc);
    end
    cycle();
    req = 4'b0001; rti = 1'b1; pc = 48'h600; cycle(); rti = 1'b0;
    checks++;
    if (taken !== 1'b1 || bpc !== 48'h100 || depth !== 2'd2 || epc !== 48'h600) begin
      errors++;
      $display("FAIL trap_over_rti got taken=%b pc=%h depth=%0d epc=%h required 1 100 2 600", taken, bpc, depth, epc);
    end
    req = 4'b0010;
    #1;
    checks++;
    if (supp !== 1'b0) begin errors++; $display("FAIL enter_suppress got %b required 0", supp); end
    cycle(); req = 4'h0;
    checks++;
    if (taken !== 1'b0 || depth !== 2'd2 || df !== 1'b0) begin
      errors++;
      $display("FAIL enter_drop got taken=%b depth=%0d df=%b required 0 2 0", taken, depth, df);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001; pc = 48'h400; cycle(); req = 4'h0;
    checks++;
    if (taken !== 1'b1 || depth !== 2'd1) begin
      errors++;
      $display("FAIL async_setup got taken=%b depth=%0d required 1 1", taken, depth);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({taken, bpc, cause, epc, depth, in_trap, df} !== '0) begin
      errors++;
      $display("FAIL async_reset got taken=%b pc=%h cause=%0d epc=%h depth=%0d in_trap=%b df=%b required all 0",
               taken, bpc, cause, epc, depth, in_trap, df);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit exp_s;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req   = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
      mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rti   = ($urandom_range(0, 2) == 0);
      stall = ($urandom_range(0, 4) == 0);
      pc    = {16'h0, 32'($urandom)};
      #1;
      exp_s = m_supp();
      checks++;
      if (supp !== exp_s) begin
        errors++;
        $display("FAIL rand_suppress n=%0d got %b required %b", n, supp, exp_s);
      end
      cycle();
      checks++;
      if (taken !== m_redir || (m_redir && bpc !== m_pc) || depth !== 2'(stk.size()) ||
          cause !== m_cause() || epc !== m_epc() || df !== m_df || in_trap !== (stk.size() != 0)) begin
        errors++;
        $display("FAIL rand_state n=%0d got taken=%b pc=%h depth=%0d cause=%0d epc=%h df=%b required %b %h %0d %0d %h %b",
                 n, taken, bpc, depth, cause, epc, df, m_redir, m_pc, stk.size(), m_cause(), m_epc(), m_df);
      end
      if (m_halt && $urandom_range(0, 5) == 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_single_trap();
    test_priority_mask();
    test_nesting();
    test_double_fault();
    test_stall_collision();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
# trap_unit

Parametrised trap controller for the Amber execute stage. It collects per-source trap requests raised by EX (signed overflow, shift-range, capability faults and similar), priority-encodes them, and suppresses the faulting GP write in the same cycle. On the following cycle it issues a one-cycle redirect to a per-cause vector. It keeps a nesting stack of {cause, EPC} so handlers can be re-entered and unwound by a return-from-trap, and it halts on stack overflow (double fault).

## Interface
- N_SRC, 4: number of trap sources; index 0 is highest priority.
- ADDR_W, 48: PC/address width.
- VEC_BASE, 48'h0000_0100: vector table base.
- VEC_SHIFT, 4: log2 of vector spacing in words.
- DEPTH, 2: nesting stack entries (≥1).
- CAUSE_W, $clog2(N_SRC) (min 1): cause field width.
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset, asynchronous, active-low.
- iw_trap_req  in  N_SRC  per-source trap request for the instruction currently in EX.
- iw_trap_mask  in  N_SRC  1 = source enabled.
- iw_pc  in  ADDR_W  PC of the instruction in EX.
- iw_stall  in  1  EX stalled; no capture or return this cycle.
- iw_rti  in  1  return-from-trap instruction in EX.
- ow_wb_suppress  out  1  combinational: kill the GP/SR/AR write of the current EX instruction.
- ow_branch_taken  out  1  registered one-cycle redirect pulse.
- ow_branch_pc  out  ADDR_W  redirect target; valid while ow_branch_taken is high.
- ow_cause  out  CAUSE_W  cause at top of stack.
- ow_epc  out  ADDR_W  EPC at top of stack.
- ow_depth  out  $clog2(DEPTH+1)  current nesting depth.
- ow_in_trap  out  1  ow_depth != 0.
- ow_double_fault  out  1  sticky; set on entry into HALT.

## Operation
- Effective request: eff = iw_trap_req & iw_trap_mask. Selected cause = lowest set index of eff.
- FSM states: RUN, ENTER, RETURN, HALT. Reset state is RUN.
- RUN:
  - If eff≠0 and !iw_stall and depth<DEPTH:
    - push {cause, iw_pc}; depth+1.
    - Next state ENTER; branch_pc = VEC_BASE + (cause << VEC_SHIFT), zero-extended to ADDR_W, modulo 2^ADDR_W.
  - If eff≠0 and !iw_stall and depth==DEPTH:
    - Next state HALT; stack unchanged; double_fault set.
  - Otherwise, if iw_rti and !iw_stall and depth>0:
    - Next state RETURN; branch_pc = top EPC + 1 (mod 2^ADDR_W); pop; depth−1.
  - iw_rti with depth==0 is ignored (no redirect).
- Priority: a trap wins over iw_rti in the same cycle. No pop occurs in that case.
- ENTER / RETURN: ow_branch_taken=1 for exactly this cycle. Then the FSM returns unconditionally to RUN. Requests and rti are ignored here, because the pipeline is being flushed.
- HALT: ow_branch_taken=0 and all inputs are ignored. Only reset exits HALT.
- ow_wb_suppress = (state==RUN) & (eff≠0). It asserts even when iw_stall=1, so a stalled faulting instruction never writes.
- The stack is a LIFO. ow_cause/ow_epc reflect the top entry and are 0 when depth==0.

## Timing
- Reset: state=RUN. The following outputs are 0: ow_branch_taken, ow_branch_pc, ow_cause, ow_epc, ow_depth, ow_in_trap, ow_double_fault. All stack entries are cleared to 0.
- Reset mid-ENTER or mid-RETURN aborts the pulse immediately (asynchronous).
- Trap latency: request sampled at edge N; ow_branch_taken is high during cycle N→N+1; ow_depth/ow_cause/ow_epc update at edge N.
- Return latency: identical. ow_depth decrements at the same edge the pulse begins.
- Back-to-back events: at most one redirect every 2 cycles. An event presented during ENTER/RETURN is dropped, not queued.
- ow_wb_suppress has zero latency (combinational from iw_trap_req, iw_trap_mask and state).

## Test plan
Parameters for all scenarios: N_SRC=4, DEPTH=2, VEC_BASE=48'h100, VEC_SHIFT=4.
- Single trap: iw_pc=48'h400, iw_trap_req=4'b0100, mask=4'hF.
  - Same cycle: ow_wb_suppress=1.
  - Next cycle: ow_branch_taken=1, branch_pc=48'h120, ow_cause=2, ow_epc=48'h400, ow_depth=1.
  - Following cycle: ow_branch_taken=0.
- Priority and mask: iw_trap_req=4'b1010, mask=4'b1101 → cause=3, branch_pc=48'h130. Separately, req=4'b0010 with mask=4'b1101 → no suppress, no redirect.
- Nesting and unwind:
  - Trap at pc=48'h400 with cause 0, then at pc=48'h500 with cause 1 → depth=2, top={1, 48'h500}.
  - First rti → branch_pc=48'h501, depth=1, top={0, 48'h400}.
  - Second rti → branch_pc=48'h401, depth=0.
  - Third rti → no redirect.
- Double fault: at depth=2, trap cause 0 → ow_double_fault=1, ow_branch_taken stays 0, depth stays 2. Further traps and rti are ignored until iw_rst low.
- Stall and collisions:
  - Trap with iw_stall=1 → ow_wb_suppress=1, no capture; releasing stall → capture on that edge.
  - Trap+rti in the same cycle at depth=1 → ENTER taken, depth=2.
  - A request during the ENTER cycle is dropped.
- Async reset: assert iw_rst low during ENTER with depth=1 → all outputs 0 immediately, without waiting for a clock edge.
